// File: rtl/hx8352_reg_reader.sv
// HX8352 8080-style read master: index write, bus turnaround, optional dummy read,
// then N read strobes with each sampled word streamed out as a one-cycle pulse.
module hx8352_reg_reader #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int RD_LOW_CYCLES  = 3,
    parameter int RD_HIGH_CYCLES = 2,
    parameter int DUMMY_READ     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [7:0]  n_words_i,
    output logic [15:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        lcd_cs_n_o,
    output logic        lcd_rs_o,
    output logic        lcd_wr_n_o,
    output logic        lcd_rd_n_o,
    output logic [15:0] lcd_db_out_o,
    output logic        lcd_db_oe_o,
    input  logic [15:0] lcd_db_in_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX_SETUP,
        S_IDX_WR_LOW,
        S_IDX_WR_HIGH,
        S_TURN,
        S_RD_LOW,
        S_RD_HIGH,
        S_DONE
    } state_t;

    // Phase counter is loaded with (duration - 1) on state entry; zero is terminal count.
    localparam logic [7:0] WR_LOW_LD  = 8'(WR_LOW_CYCLES - 1);
    localparam logic [7:0] WR_HIGH_LD = 8'(WR_HIGH_CYCLES - 1);
    localparam logic [7:0] RD_LOW_LD  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] RD_HIGH_LD = 8'(RD_HIGH_CYCLES - 1);
    localparam logic       DUMMY_EN   = (DUMMY_READ != 0);

    state_t      state_q;
    logic [7:0]  phase_q;
    logic [7:0]  words_q;
    logic        dummy_q;

    logic [15:0] rd_data_q;
    logic        rd_valid_q;
    logic        done_q;
    logic        busy_q;
    logic        cs_n_q;
    logic        rs_q;
    logic        wr_n_q;
    logic        rd_n_q;
    logic [15:0] db_out_q;
    logic        db_oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 8'd0;
            words_q    <= 8'd0;
            dummy_q    <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rs_q       <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            db_out_q   <= 16'h0000;
            db_oe_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;

            if (phase_q != 8'd0) begin
                phase_q <= phase_q - 8'd1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q  <= S_IDX_SETUP;
                            phase_q  <= 8'd0;
                            words_q  <= (n_words_i == 8'd0) ? 8'd1 : n_words_i;
                            dummy_q  <= DUMMY_EN;
                            busy_q   <= 1'b1;
                            cs_n_q   <= 1'b0;
                            rs_q     <= 1'b0;
                            wr_n_q   <= 1'b1;
                            rd_n_q   <= 1'b1;
                            db_out_q <= {8'h00, reg_addr_i};
                            db_oe_q  <= 1'b1;
                        end
                    end
                    S_IDX_SETUP: begin
                        state_q <= S_IDX_WR_LOW;
                        phase_q <= WR_LOW_LD;
                        wr_n_q  <= 1'b0;
                    end
                    S_IDX_WR_LOW: begin
                        state_q <= S_IDX_WR_HIGH;
                        phase_q <= WR_HIGH_LD;
                        wr_n_q  <= 1'b1;
                    end
                    S_IDX_WR_HIGH: begin
                        // Release the bus a full cycle before the first read strobe.
                        state_q <= S_TURN;
                        phase_q <= 8'd0;
                        db_oe_q <= 1'b0;
                        rs_q    <= 1'b1;
                    end
                    S_TURN: begin
                        state_q <= S_RD_LOW;
                        phase_q <= RD_LOW_LD;
                        rd_n_q  <= 1'b0;
                    end
                    S_RD_LOW: begin
                        state_q <= S_RD_HIGH;
                        phase_q <= RD_HIGH_LD;
                        rd_n_q  <= 1'b1;
                        if (dummy_q) begin
                            dummy_q <= 1'b0;
                        end else begin
                            rd_data_q  <= lcd_db_in_i;
                            rd_valid_q <= 1'b1;
                            words_q    <= words_q - 8'd1;
                        end
                    end
                    S_RD_HIGH: begin
                        if (words_q != 8'd0) begin
                            state_q <= S_RD_LOW;
                            phase_q <= RD_LOW_LD;
                            rd_n_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            phase_q <= 8'd0;
                            cs_n_q  <= 1'b1;
                            rs_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        db_out_q <= 16'h0000;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cs_n_q  <= 1'b1;
                        rs_q    <= 1'b1;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        db_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign lcd_cs_n_o   = cs_n_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_wr_n_o   = wr_n_q;
    assign lcd_rd_n_o   = rd_n_q;
    assign lcd_db_out_o = db_out_q;
    assign lcd_db_oe_o  = db_oe_q;

endmodule

// File: tb/tb_hx8352_reg_reader.sv
// Scoreboard bench for hx8352_reg_reader: one instance with defaults (dummy read on),
// one with DUMMY_READ=0; panel model returns base + read-strobe index.
module tb_hx8352_reg_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  reg_addr, n_words;

    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        done_a, done_b;
    logic        busy_a, busy_b;
    logic        cs_n_a, cs_n_b;
    logic        rs_a, rs_b;
    logic        wr_n_a, wr_n_b;
    logic        rd_n_a, rd_n_b;
    logic [15:0] db_out_a, db_out_b;
    logic        oe_a, oe_b;
    logic [15:0] db_in_a, db_in_b;

    logic        use_const_a;
    logic [15:0] base_a, base_b;
    int          fall_cnt_a, fall_cnt_b;

    int checks = 0;
    int errors = 0;

    int falls_a = 0, valids_a = 0, dones_a = 0, busy_cyc_a = 0;
    int falls_b = 0, valids_b = 0, dones_b = 0, busy_cyc_b = 0;
    logic prev_rd_n_a = 1'b1, prev_rd_n_b = 1'b1;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    logic [7:0] ctl_a;
    assign ctl_a = {busy_a, cs_n_a, rs_a, wr_n_a, rd_n_a, oe_a, rd_valid_a, done_a};
    localparam logic [7:0] CTL_IDLE = 8'b0111_1000;

    assign db_in_a = use_const_a ? 16'h0052 : base_a + 16'(fall_cnt_a);
    assign db_in_b = base_b + 16'(fall_cnt_b);

    always #5 clk = ~clk;

    hx8352_reg_reader dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .reg_addr_i(reg_addr), .n_words_i(n_words),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .done_o(done_a), .busy_o(busy_a),
        .lcd_cs_n_o(cs_n_a), .lcd_rs_o(rs_a), .lcd_wr_n_o(wr_n_a), .lcd_rd_n_o(rd_n_a),
        .lcd_db_out_o(db_out_a), .lcd_db_oe_o(oe_a), .lcd_db_in_i(db_in_a)
    );

    hx8352_reg_reader #(.DUMMY_READ(0)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .reg_addr_i(reg_addr), .n_words_i(n_words),
        .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .done_o(done_b), .busy_o(busy_b),
        .lcd_cs_n_o(cs_n_b), .lcd_rs_o(rs_b), .lcd_wr_n_o(wr_n_b), .lcd_rd_n_o(rd_n_b),
        .lcd_db_out_o(db_out_b), .lcd_db_oe_o(oe_b), .lcd_db_in_i(db_in_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input bit sel_b, input int limit, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sel_b ? done_b : done_a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Expected control vector for the default-parameter single-word read, by cycle after start.
    function automatic logic [7:0] exp_ctl(input int c);
        logic bsy, csn, rsv, wrn, rdn, oe, vld, dn;
        bsy = (c >= 1 && c <= 17);
        csn = !(c >= 1 && c <= 16);
        rsv = !(c >= 1 && c <= 5);
        wrn = !(c == 2 || c == 3);
        rdn = !((c >= 7 && c <= 9) || (c >= 12 && c <= 14));
        oe  = (c >= 1 && c <= 5);
        vld = (c == 15);
        dn  = (c == 17);
        return {bsy, csn, rsv, wrn, rdn, oe, vld, dn};
    endfunction

    initial begin
        int f0, v0, d0, b0;

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        reg_addr = 8'h00;
        n_words = 8'd1;
        use_const_a = 1'b1;
        base_a = 16'h0000;
        base_b = 16'h0000;
        fall_cnt_a = 0;
        fall_cnt_b = 0;

        fork
            forever begin
                @(negedge clk);
                if (!busy_a) fall_cnt_a = 0;
                if (prev_rd_n_a && !rd_n_a) begin
                    fall_cnt_a++;
                    falls_a++;
                end
                prev_rd_n_a = rd_n_a;
                if (!rd_n_a) check("a_oe_during_rd", 32'(oe_a), 32'd0);
                if (rd_valid_a) begin
                    valids_a++;
                    if (exp_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_word: got %h, expected none", rd_data_a);
                    end else begin
                        check("a_rd_data", 32'(rd_data_a), 32'(exp_a.pop_front()));
                    end
                end
                if (done_a) dones_a++;
                if (busy_a) busy_cyc_a++;
            end
            forever begin
                @(negedge clk);
                if (!busy_b) fall_cnt_b = 0;
                if (prev_rd_n_b && !rd_n_b) begin
                    fall_cnt_b++;
                    falls_b++;
                end
                prev_rd_n_b = rd_n_b;
                if (!rd_n_b) check("b_oe_during_rd", 32'(oe_b), 32'd0);
                if (rd_valid_b) begin
                    valids_b++;
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_word: got %h, expected none", rd_data_b);
                    end else begin
                        check("b_rd_data", 32'(rd_data_b), 32'(exp_b.pop_front()));
                    end
                end
                if (done_b) dones_b++;
                if (busy_b) busy_cyc_b++;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctl_a", 32'(ctl_a), 32'(CTL_IDLE));
        check("reset_db_out_a", 32'(db_out_a), 32'h0);
        check("reset_rd_data_a", 32'(rd_data_a), 32'h0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word, dummy read, cycle-exact control sequence
        exp_a.push_back(16'h0052);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            check($sformatf("t1_ctl_cyc%0d", c), 32'(ctl_a), 32'(exp_ctl(c)));
            if (c == 1) check("t1_db_out_index", 32'(db_out_a), 32'h0000);
            @(negedge clk);
        end
        check("t1_rd_data_hold", 32'(rd_data_a), 32'h0052);
        use_const_a = 1'b0;

        // No dummy read, four words
        reg_addr = 8'h22;
        n_words = 8'd4;
        base_b = 16'h0FFF;
        for (int i = 0; i < 4; i++) exp_b.push_back(16'h1000 + 16'(i));
        f0 = falls_b; v0 = valids_b; d0 = dones_b; b0 = busy_cyc_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t2_db_out_index", 32'(db_out_b), 32'h0022);
        wait_done(1'b1, 100, "t2");
        repeat (3) @(negedge clk);
        check("t2_valids", 32'(valids_b - v0), 32'd4);
        check("t2_rd_falls", 32'(falls_b - f0), 32'd4);
        check("t2_busy_cycles", 32'(busy_cyc_b - b0), 32'd27);
        check("t2_dones", 32'(dones_b - d0), 32'd1);
        check("t2_queue_empty", 32'(exp_b.size()), 32'd0);

        // n_words = 0 behaves as 1
        reg_addr = 8'h00;
        n_words = 8'd0;
        base_a = 16'h2000;
        exp_a.push_back(16'h2002);
        f0 = falls_a; v0 = valids_a; d0 = dones_a; b0 = busy_cyc_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 100, "t3");
        repeat (3) @(negedge clk);
        check("t3_valids", 32'(valids_a - v0), 32'd1);
        check("t3_rd_falls", 32'(falls_a - f0), 32'd2);
        check("t3_busy_cycles", 32'(busy_cyc_a - b0), 32'd17);
        check("t3_dones", 32'(dones_a - d0), 32'd1);

        // Start pulsed while busy is ignored; start held across done relaunches
        n_words = 8'd1;
        base_a = 16'h3000;
        exp_a.push_back(16'h3002);
        exp_a.push_back(16'h3002);
        v0 = valids_a; d0 = dones_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        repeat (7) @(negedge clk);
        check("t4_done_cyc17", 32'(done_a), 32'd1);
        @(negedge clk);
        check("t4_idle_gap_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("t4_relaunch_busy", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        wait_done(1'b0, 100, "t4");
        repeat (30) @(negedge clk);
        check("t4_dones", 32'(dones_a - d0), 32'd2);
        check("t4_valids", 32'(valids_a - v0), 32'd2);
        check("t4_idle_after", 32'(busy_a), 32'd0);

        // Reset during RD_LOW of word 2 of 3
        n_words = 8'd3;
        base_a = 16'h4000;
        exp_a.push_back(16'h4002);
        v0 = valids_a; d0 = dones_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (17) @(negedge clk);
        check("t5_in_rd_low_w2", 32'(rd_n_a), 32'd0);
        #1 rst = 1'b1;
        #1 check("t5_async_release", 32'(ctl_a), 32'(CTL_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(dones_a - d0), 32'd0);
        check("t5_valids", 32'(valids_a - v0), 32'd1);
        check("t5_queue_empty", 32'(exp_a.size()), 32'd0);
        n_words = 8'd1;
        base_a = 16'h5000;
        exp_a.push_back(16'h5002);
        d0 = dones_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 100, "t5_after");
        repeat (3) @(negedge clk);
        check("t5_after_dones", 32'(dones_a - d0), 32'd1);

        // 255 words with dummy read
        n_words = 8'd255;
        base_a = 16'h6000;
        for (int i = 0; i < 255; i++) exp_a.push_back(16'h6002 + 16'(i));
        f0 = falls_a; v0 = valids_a; d0 = dones_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 2000, "t6");
        repeat (3) @(negedge clk);
        check("t6_rd_falls", 32'(falls_a - f0), 32'd256);
        check("t6_valids", 32'(valids_a - v0), 32'd255);
        check("t6_dones", 32'(dones_a - d0), 32'd1);
        check("t6_queue_empty", 32'(exp_a.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
